// File: rtl/vexp_if.sv
// Handshake bundle for the vexp lane: operand in via valid_in/ready_in,
// result out via valid_out/ready_out.
interface vexp_if;
  logic [15:0] operand;
  logic        valid_in;
  logic        ready_in;
  logic [15:0] result;
  logic        valid_out;
  logic        ready_out;

  modport master (
    output operand, valid_in, ready_out,
    input  ready_in, result, valid_out
  );

  modport slave (
    input  operand, valid_in, ready_out,
    output ready_in, result, valid_out
  );
endinterface

// File: rtl/vexp.sv
// BF16 e^x lane: five register stages computing 2^(x*log2 e) with a
// 16-entry table plus linear interpolation, whole-pipe stall on back-pressure.
module vexp (
  input  logic  CLK,
  input  logic  RST,
  vexp_if.slave vexpif
);
  localparam logic signed [17:0] LOG2E = 18'sh17154;

  logic stall, adv;
  assign stall          = vexpif.valid_out && !vexpif.ready_out;
  assign adv            = !stall;
  assign vexpif.ready_in = adv;

  logic               v1, v2, v3, v4, vout;
  logic               sp1, sp2, sp3, sp4;
  logic [15:0]        sv1, sv2, sv3, sv4;
  logic signed [24:0] s1_fx;
  logic signed [25:0] s2_t;
  logic signed [9:0]  s3_n;
  logic [17:0]        s3_base, s3_diff;
  logic [11:0]        s3_frac;
  logic signed [10:0] s4_e;
  logic [6:0]         s4_m;
  logic [15:0]        result_q;

  assign vexpif.valid_out = vout;
  assign vexpif.result    = result_q;

  function automatic logic [17:0] pow2_tab(input logic [4:0] i);
    case (i)
      5'd0:    pow2_tab = 18'd65536;
      5'd1:    pow2_tab = 18'd68438;
      5'd2:    pow2_tab = 18'd71468;
      5'd3:    pow2_tab = 18'd74631;
      5'd4:    pow2_tab = 18'd77936;
      5'd5:    pow2_tab = 18'd81386;
      5'd6:    pow2_tab = 18'd84990;
      5'd7:    pow2_tab = 18'd88753;
      5'd8:    pow2_tab = 18'd92682;
      5'd9:    pow2_tab = 18'd96785;
      5'd10:   pow2_tab = 18'd101070;
      5'd11:   pow2_tab = 18'd105545;
      5'd12:   pow2_tab = 18'd110218;
      5'd13:   pow2_tab = 18'd115098;
      5'd14:   pow2_tab = 18'd120194;
      5'd15:   pow2_tab = 18'd125515;
      default: pow2_tab = 18'd131072;
    endcase
  endfunction

  // Stage 1: classify specials and convert x to Q9.16
  logic        sgn;
  logic [7:0]  ex;
  logic [6:0]  man;
  logic [7:0]  sig;
  logic        spec_c;
  logic [15:0] sval_c;
  logic [24:0] mag;
  logic signed [24:0] fx_c;

  assign {sgn, ex, man} = vexpif.operand;
  assign sig = {1'b1, man};

  always_comb begin
    spec_c = 1'b1;
    sval_c = '0;
    if (ex == 8'hFF && man != 7'd0)                 sval_c = 16'h7FC0;
    else if (ex == 8'hFF)                           sval_c = sgn ? 16'h0000 : 16'h7F80;
    else if (ex == 8'h00)                           sval_c = 16'h3F80;
    else if (!sgn && vexpif.operand[14:0] >= 15'h42B2) sval_c = 16'h7F80;
    else if (sgn && vexpif.operand[14:0] >= 15'h42AF)  sval_c = 16'h0000;
    else                                            spec_c = 1'b0;
  end

  always_comb begin
    if (ex >= 8'd118) mag = 25'(sig) << (ex - 8'd118);
    else              mag = 25'(sig) >> (8'd118 - ex);
    fx_c = sgn ? -mag : mag;
  end

  // Stage 2: t = x * log2(e), floored to Q9.16
  logic signed [42:0] prod;
  logic signed [25:0] t_c;
  always_comb begin
    prod = s1_fx * LOG2E;
    t_c  = 26'(prod >>> 16);
  end

  // Stage 3: split t into integer n and fraction f, fetch interpolation points
  logic [3:0]  idx_c;
  logic [17:0] base_c, next_c;
  always_comb begin
    idx_c  = s2_t[15:12];
    base_c = pow2_tab({1'b0, idx_c});
    next_c = pow2_tab({1'b0, idx_c} + 5'd1);
  end

  // Stage 4: interpolate 2^f, round mantissa to nearest-even
  logic [29:0]        ip;
  logic [15:0]        pf;
  logic               rup;
  logic [7:0]         mr;
  logic signed [10:0] e_c;
  always_comb begin
    ip  = 30'(s3_diff) * 30'(s3_frac);
    pf  = 16'(s3_base + 18'(ip >> 12));
    rup = pf[8] && ((|pf[7:0]) || pf[9]);
    mr  = {1'b0, pf[15:9]} + {7'd0, rup};
    e_c = 11'(s3_n) + 11'sd127 + $signed({10'd0, mr[7]});
  end

  // Output pack: exponent range checks flush to +0 or saturate to +inf
  logic [15:0] res_c;
  always_comb begin
    if (sp4)                    res_c = sv4;
    else if (s4_e >= 11'sd255)  res_c = 16'h7F80;
    else if (s4_e <= 11'sd0)    res_c = '0;
    else                        res_c = {1'b0, s4_e[7:0], s4_m};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      {v1, v2, v3, v4, vout} <= '0;
      result_q <= '0;
    end else if (adv) begin
      v1       <= vexpif.valid_in;
      v2       <= v1;
      v3       <= v2;
      v4       <= v3;
      vout     <= v4;
      result_q <= res_c;
    end
  end

  always_ff @(posedge CLK) begin
    if (adv) begin
      sp1     <= spec_c;
      sv1     <= sval_c;
      s1_fx   <= fx_c;
      sp2     <= sp1;
      sv2     <= sv1;
      s2_t    <= t_c;
      sp3     <= sp2;
      sv3     <= sv2;
      s3_n    <= s2_t[25:16];
      s3_base <= base_c;
      s3_diff <= next_c - base_c;
      s3_frac <= s2_t[11:0];
      sp4     <= sp3;
      sv4     <= sv3;
      s4_e    <= e_c;
      s4_m    <= mr[6:0];
    end
  end
endmodule

// File: tb/tb_vexp.sv
// Directed bench for vexp: latency, streaming, specials/boundaries,
// back-pressure and mid-stream reset against hand-computed BF16 results.
module tb_vexp;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  vexp_if vif ();
  vexp dut (.CLK(clk), .RST(rst), .vexpif(vif));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    vif.valid_in = 1'b0;
    vif.ready_out = 1'b1;
    vif.operand = '0;
    repeat (5) tick();
    nvec++;
    if (vif.valid_out !== 1'b0) begin nerr++; $display("FAIL reset_valid_out got %b want 0", vif.valid_out); end
    nvec++;
    if (vif.ready_in !== 1'b1) begin nerr++; $display("FAIL reset_ready_in got %b want 1", vif.ready_in); end
    nvec++;
    if (vif.result !== 16'h0000) begin nerr++; $display("FAIL reset_result got %h want 0000", vif.result); end
    rst = 1'b0;
    tick();
    nvec++;
    if (vif.valid_out !== 1'b0 || vif.ready_in !== 1'b1) begin
      nerr++; $display("FAIL post_reset got valid_out=%b ready_in=%b want 0/1", vif.valid_out, vif.ready_in);
    end
  endtask

  task automatic test_latency();
    logic [15:0] ops  [2] = '{16'h3F80, 16'h0000};
    logic [15:0] want [2] = '{16'h402E, 16'h3F80};
    vif.ready_out = 1'b1;
    for (int i = 0; i < 2; i++) begin
      vif.operand = ops[i];
      vif.valid_in = 1'b1;
      tick();
      vif.valid_in = 1'b0;
      for (int c = 1; c <= 3; c++) begin
        tick();
        nvec++;
        if (vif.valid_out !== 1'b0) begin nerr++; $display("FAIL lat_early op=%h edge+%0d got valid_out=%b want 0", ops[i], c, vif.valid_out); end
      end
      tick();
      nvec++;
      if (vif.valid_out !== 1'b1 || vif.result !== want[i]) begin
        nerr++; $display("FAIL lat_result op=%h got valid=%b result=%h want 1/%h", ops[i], vif.valid_out, vif.result, want[i]);
      end
      tick();
      nvec++;
      if (vif.valid_out !== 1'b0) begin nerr++; $display("FAIL lat_single op=%h got valid_out=%b want 0", ops[i], vif.valid_out); end
    end
  endtask

  task automatic test_streaming();
    logic [15:0] ops  [4] = '{16'h3F80, 16'hBF80, 16'h4000, 16'h3F00};
    logic [15:0] want [4] = '{16'h402E, 16'h3EBC, 16'h40EC, 16'h3FD3};
    int sent = 0;
    int got = 0;
    int first = -1;
    vif.ready_out = 1'b1;
    for (int c = 0; c < 30 && got < 4; c++) begin
      vif.valid_in = (sent < 4);
      vif.operand  = ops[(sent < 4) ? sent : 0];
      #1;
      if (vif.valid_in && vif.ready_in) sent++;
      tick();
      if (vif.valid_out) begin
        if (got == 0) first = c;
        nvec++;
        if (vif.result !== want[got] || c != first + got) begin
          nerr++; $display("FAIL stream_%0d got %h at cycle %0d want %h at cycle %0d", got, vif.result, c, want[got], first + got);
        end
        got++;
      end
    end
    vif.valid_in = 1'b0;
    nvec++;
    if (got != 4 || first != 4) begin nerr++; $display("FAIL stream_count got %0d results first at %0d want 4 first at 4", got, first); end
    repeat (2) tick();
  endtask

  task automatic test_specials();
    logic [15:0] ops  [11] = '{16'h42C8, 16'hC2C8, 16'h7FC1, 16'hFF80, 16'h7F80, 16'h42B1,
                               16'h42B2, 16'hC2AE, 16'hC2AF, 16'h0001, 16'h8000};
    logic [15:0] want [11] = '{16'h7F80, 16'h0000, 16'h7FC0, 16'h0000, 16'h7F80, 16'h7F4D,
                               16'h7F80, 16'h00B3, 16'h0000, 16'h3F80, 16'h3F80};
    int sent = 0;
    int got = 0;
    vif.ready_out = 1'b1;
    for (int c = 0; c < 40 && got < 11; c++) begin
      vif.valid_in = (sent < 11);
      vif.operand  = ops[(sent < 11) ? sent : 0];
      #1;
      if (vif.valid_in && vif.ready_in) sent++;
      tick();
      if (vif.valid_out) begin
        nvec++;
        if (vif.result !== want[got]) begin
          nerr++; $display("FAIL special op=%h got %h want %h", ops[got], vif.result, want[got]);
        end
        got++;
      end
    end
    vif.valid_in = 1'b0;
    nvec++;
    if (got != 11) begin nerr++; $display("FAIL special_count got %0d want 11", got); end
    repeat (2) tick();
  endtask

  task automatic test_back_pressure();
    logic [15:0] ops  [6] = '{16'h3F80, 16'hBF80, 16'h4000, 16'h0000, 16'h42C8, 16'h7FC1};
    logic [15:0] want [6] = '{16'h402E, 16'h3EBC, 16'h40EC, 16'h3F80, 16'h7F80, 16'h7FC0};
    int sent = 0;
    int got = 0;
    int stalls = 0;
    int extra = 0;
    logic held_ok = 1'b0;
    logic [15:0] held = '0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      vif.ready_out = !(c >= 5 && c <= 8);
      vif.valid_in  = (sent < 6);
      vif.operand   = ops[(sent < 6) ? sent : 0];
      #1;
      if (vif.valid_out && !vif.ready_out) begin
        stalls++;
        nvec++;
        if (vif.ready_in !== 1'b0) begin nerr++; $display("FAIL bp_ready_in cycle %0d got %b want 0", c, vif.ready_in); end
        if (held_ok) begin
          nvec++;
          if (vif.result !== held) begin nerr++; $display("FAIL bp_hold cycle %0d got %h want %h", c, vif.result, held); end
        end
        held = vif.result;
        held_ok = 1'b1;
      end else begin
        held_ok = 1'b0;
      end
      if (vif.valid_out && vif.ready_out) begin
        nvec++;
        if (vif.result !== want[got]) begin nerr++; $display("FAIL bp_result_%0d got %h want %h", got, vif.result, want[got]); end
        got++;
      end
      if (vif.valid_in && vif.ready_in) sent++;
      tick();
    end
    vif.valid_in = 1'b0;
    vif.ready_out = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (vif.valid_out) extra++;
      tick();
    end
    nvec++;
    if (got != 6 || sent != 6 || extra != 0) begin
      nerr++; $display("FAIL bp_count got results=%0d sent=%0d extra=%0d want 6/6/0", got, sent, extra);
    end
    nvec++;
    if (stalls != 4) begin nerr++; $display("FAIL bp_stalls got %0d want 4", stalls); end
  endtask

  task automatic test_mid_reset();
    logic [15:0] ops [3] = '{16'h3F80, 16'hBF80, 16'h4000};
    int leaked = 0;
    int c_out = -1;
    vif.ready_out = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vif.operand = ops[i];
      vif.valid_in = 1'b1;
      tick();
    end
    vif.valid_in = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    nvec++;
    if (vif.valid_out !== 1'b0) begin nerr++; $display("FAIL midrst_valid got %b want 0", vif.valid_out); end
    for (int c = 0; c < 8; c++) begin
      tick();
      if (vif.valid_out !== 1'b0) leaked++;
    end
    nvec++;
    if (leaked != 0) begin nerr++; $display("FAIL midrst_leak got %0d results want 0", leaked); end
    vif.operand = 16'h4000;
    vif.valid_in = 1'b1;
    tick();
    vif.valid_in = 1'b0;
    for (int c = 1; c <= 10 && c_out < 0; c++) begin
      tick();
      if (vif.valid_out) begin
        c_out = c;
        nvec++;
        if (vif.result !== 16'h40EC) begin nerr++; $display("FAIL midrst_new got %h want 40EC", vif.result); end
      end
    end
    nvec++;
    if (c_out != 4) begin nerr++; $display("FAIL midrst_latency got %0d want 4", c_out); end
  endtask

  initial begin
    vif.operand = '0;
    vif.valid_in = 1'b0;
    vif.ready_out = 1'b1;
    test_reset();
    test_latency();
    test_streaming();
    test_specials();
    test_back_pressure();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
